// File: rtl/bcd_display_pkg.sv
// Shared constants for the memory-mapped 4-digit 7-segment display scanner.
package bcd_display_pkg;

    localparam logic [3:0] MMIO_TAG_DEFAULT = 4'h5;

    typedef enum logic [1:0] {
        REG_VALUE = 2'd0,
        REG_CTRL  = 2'd1,
        REG_RSVD2 = 2'd2,
        REG_RSVD3 = 2'd3
    } reg_sel_e;

    localparam int          CTRL_EN_BIT = 0;
    localparam int          CTRL_DP_LSB = 4;
    localparam logic [7:0]  CTRL_RESET  = 8'h01;
    localparam logic [11:0] DISP_OFF    = 12'hFFF;

    // Active-low gfedcba glyphs, entry [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module hex_to_seg7
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/bcd_display_scanner.sv
// MMIO 4-digit 7-segment scanner: VALUE/CTRL registers, digit-slot divider and registered {an, seg} output.
// Optional BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int         CLK_DIV  = 100000,
    parameter logic [3:0] MMIO_TAG = MMIO_TAG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [11:0] display_out
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [15:0]      value_q, value_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      disp_q, disp_d;

    logic       sel;
    reg_sel_e   reg_sel;
    logic       tick;
    logic [1:0] slot_idx;
    logic [3:0] nibble;
    logic [6:0] glyph_n;
    logic [3:0] dp_on;
    logic       blank;
    logic [11:0] slot_word;
    logic       unused_bits;

    assign sel      = (Address[31:28] == MMIO_TAG);
    assign reg_sel  = reg_sel_e'(Address[3:2]);
    assign tick     = (div_q == DIV_LAST);
    // 2-bit add wraps 3 -> 0, giving the rotating digit order for free.
    assign slot_idx = idx_q + 2'd1;
    assign nibble   = value_q[{slot_idx, 2'b00} +: 4];
    assign dp_on    = ctrl_q[CTRL_DP_LSB +: 4];
    assign unused_bits = ^{Address[27:4], Address[1:0], Write_data[31:16]};

    hex_to_seg7 u_glyph (
        .nibble_i (nibble),
        .seg_n_o  (glyph_n)
    );

`ifdef BCD_LEADING_ZERO_BLANK_EN
    assign blank = (slot_idx != 2'd0) && ((value_q >> {slot_idx, 2'b00}) == 16'h0000);
`else
    assign blank = 1'b0;
`endif

    assign slot_word = {~(4'b0001 << slot_idx),
                        blank ? 8'hFF : {~dp_on[slot_idx], glyph_n}};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        value_d = value_q;
        ctrl_d  = ctrl_q;
        idx_d   = idx_q;
        disp_d  = disp_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);

        if (MemWrite && sel) begin
            case (reg_sel)
                REG_VALUE: value_d = Write_data[15:0];
                REG_CTRL:  ctrl_d  = Write_data[7:0];
                default:   ;
            endcase
        end

        if (tick) begin
            idx_d  = slot_idx;
            disp_d = ctrl_q[CTRL_EN_BIT] ? slot_word : DISP_OFF;
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead && sel) begin
            case (reg_sel)
                REG_VALUE: Read_data = {16'h0000, value_q};
                REG_CTRL:  Read_data = {24'h000000, ctrl_q};
                default:   Read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates make a tick in the same edge as a write see the pre-write VALUE/CTRL.
        if (reset) begin
            value_q <= '0;
            ctrl_q  <= CTRL_RESET;
            div_q   <= '0;
            idx_q   <= 2'd3;
            disp_q  <= DISP_OFF;
        end else begin
            value_q <= value_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
        end
    end

    assign display_out = disp_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with CLK_DIV=4 and MMIO_TAG=5.
module tb_bcd_display_scanner;

    localparam int          CLK_DIV = 4;
    localparam logic [3:0]  TAG     = 4'h5;
    localparam logic [31:0] A_VALUE = 32'h5000_0000;
    localparam logic [31:0] A_CTRL  = 32'h5000_0004;
    localparam logic [31:0] A_RSVD2 = 32'h5000_0008;
    localparam logic [31:0] A_RSVD3 = 32'h5000_000C;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [11:0] display_out;

    bcd_display_scanner #(
        .CLK_DIV  (CLK_DIV),
        .MMIO_TAG (TAG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Address     (Address),
        .Write_data  (Write_data),
        .Read_data   (Read_data),
        .display_out (display_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record per register setting: expected display word for slots 0..3.
    typedef struct packed {
        logic [15:0]      value;
        logic [7:0]       ctrl;
        logic [3:0][11:0] w;
    } vec_t;

    vec_t             tab [8];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [11:0]      exp_q [$];
    logic [11:0]      cur_exp;
    logic [3:0][11:0] m_slots;
    logic             m_en;
    int               m_idx;
    int               n_edges;
    logic             last_tick;

    function automatic vec_t mk(input logic [15:0] v, input logic [7:0] c,
                                input logic [11:0] w0, input logic [11:0] w1,
                                input logic [11:0] w2, input logic [11:0] w3);
        vec_t r;
        r.value = v;
        r.ctrl  = c;
        r.w     = {w3, w2, w1, w0};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: push the expected slot word if this edge ticks, then compare after the edge.
    task automatic step();
        logic in_reset;
        logic tick;
        int   nidx;
        in_reset = reset;
        tick     = !in_reset && (((n_edges + 1) % CLK_DIV) == 0);
        nidx     = (m_idx == 3) ? 0 : m_idx + 1;
        if (tick) exp_q.push_back(m_en ? m_slots[nidx] : 12'hFFF);
        @(posedge clk);
        #1;
        if (in_reset) begin
            n_edges = 0;
            m_idx   = 3;
            m_en    = 1'b1;
            m_slots = tab[0].w;
            exp_q.delete();
            cur_exp = 12'hFFF;
        end else begin
            n_edges++;
            if (tick) begin
                m_idx   = nidx;
                cur_exp = exp_q.pop_front();
            end
        end
        last_tick = tick;
        check("display_out", {20'h0, display_out}, {20'h0, cur_exp});
    endtask

    task automatic wait_after_tick();
        do step(); while (!last_tick);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        step();
        MemWrite   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        MemRead = 1'b1;
        #1;
        check($sformatf("read_%h", a), Read_data, exp);
        MemRead = 1'b0;
    endtask

    initial begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        tab[0] = mk(16'h0000, 8'h01, 12'hEC0, 12'hDFF, 12'hBFF, 12'h7FF);
        tab[6] = mk(16'h0005, 8'hF1, 12'hE12, 12'hDFF, 12'hBFF, 12'h7FF);
        tab[7] = mk(16'h0005, 8'h01, 12'hE92, 12'hDFF, 12'hBFF, 12'h7FF);
        tab[5] = mk(16'h0E79, 8'h01, 12'hE90, 12'hDF8, 12'hB86, 12'h7FF);
`else
        tab[0] = mk(16'h0000, 8'h01, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);
        tab[6] = mk(16'h0005, 8'hF1, 12'hE12, 12'hD40, 12'hB40, 12'h740);
        tab[7] = mk(16'h0005, 8'h01, 12'hE92, 12'hDC0, 12'hBC0, 12'h7C0);
        tab[5] = mk(16'h0E79, 8'h01, 12'hE90, 12'hDF8, 12'hB86, 12'h7C0);
`endif
        tab[1] = mk(16'h1234, 8'h01, 12'hE99, 12'hDB0, 12'hBA4, 12'h7F9);
        tab[2] = mk(16'h1234, 8'h31, 12'hE19, 12'hD30, 12'hBA4, 12'h7F9);
        tab[3] = mk(16'hABCD, 8'hF1, 12'hE21, 12'hD46, 12'hB03, 12'h708);
        tab[4] = mk(16'h8F60, 8'h01, 12'hEC0, 12'hD82, 12'hB8E, 12'h780);

        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; Write_data = '0;
        m_slots = tab[0].w; m_en = 1'b1; m_idx = 3; n_edges = 0;
        cur_exp = 12'hFFF; last_tick = 1'b0;

        repeat (2) step();
        reset = 1'b0;
        rd(A_VALUE, 32'h0);
        rd(A_CTRL, 32'h1);
        repeat (2 * CLK_DIV) step();

        // Table sweep; last entry leaves CTRL enabled with plain dp-off setting.
        for (int i = 1; i < 8; i++) begin
            int k;
            k = (i == 7) ? 5 : ((i == 5) ? 7 : i);
            wait_after_tick();
            wr(A_VALUE, {16'hDEAD, tab[k].value});
            wr(A_CTRL, {24'hA5A5A5, tab[k].ctrl});
            m_slots = tab[k].w;
            m_en    = tab[k].ctrl[0];
            rd(A_VALUE, {16'h0, tab[k].value});
            rd(A_CTRL, {24'h0, tab[k].ctrl});
            repeat (4 * CLK_DIV) step();
        end

        // Disable blanks every tick while the scan keeps rotating; re-enable resumes in order.
        wait_after_tick();
        wr(A_CTRL, 32'h0);
        m_en = 1'b0;
        rd(A_CTRL, 32'h0);
        repeat (3 * CLK_DIV) step();
        wr(A_CTRL, 32'h1);
        m_en = 1'b1;
        repeat (3 * CLK_DIV) step();

        // VALUE write on the tick edge: that slot shows old data, next slot new.
        while (((n_edges + 1) % CLK_DIV) != 0) step();
        wr(A_VALUE, 32'h0000_1234);
        m_slots = tab[1].w;
        repeat (2 * CLK_DIV) step();

        // Unselected and reserved accesses.
        wr(32'h4000_0000, 32'h0000_FFFF);
        rd(A_VALUE, 32'h0000_1234);
        wr(A_RSVD2, 32'h0000_00FF);
        rd(A_RSVD2, 32'h0);
        rd(A_RSVD3, 32'h0);
        rd(A_CTRL, 32'h1);
        rd(32'h4000_0004, 32'h0);
        Address = A_VALUE;
        MemRead = 1'b0;
        #1;
        check("read_idle", Read_data, 32'h0);

        // Reset dominates a concurrent write.
        Address = A_VALUE; Write_data = 32'h0000_FFFF; MemWrite = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; MemWrite = 1'b0;
        rd(A_VALUE, 32'h0);
        rd(A_CTRL, 32'h1);
        repeat (2 * CLK_DIV) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
